// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: command encodings,
// scan code constants, receiver states and the game-key lookup.
package ps2_pkg;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_LEFT   = 2'b01;
    localparam logic [1:0] CMD_RIGHT  = 2'b10;
    localparam logic [1:0] CMD_ROTATE = 2'b11;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Returns {is_game_key, command} for a key code qualified by the E0 prefix.
    function automatic logic [2:0] keyDecode(input logic ext, input logic [7:0] code);
        logic [2:0] result;
        result = 3'b000;
        if (ext) begin
            case (code)
                SC_LEFT:  result = {1'b1, CMD_LEFT};
                SC_RIGHT: result = {1'b1, CMD_RIGHT};
                SC_UP:    result = {1'b1, CMD_ROTATE};
                default:  result = 3'b000;
            endcase
        end else begin
            case (code)
                SC_A:    result = {1'b1, CMD_LEFT};
                SC_D:    result = {1'b1, CMD_RIGHT};
                SC_W:    result = {1'b1, CMD_ROTATE};
                default: result = 3'b000;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter,
// start/data/parity/stop framing and an inactivity timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       rx_timeout
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     clkSync_q, dataSync_q;
    logic [FCW-1:0] filtCnt_q, filtCnt_d;
    logic           filtLevel_q, filtLevel_d;
    logic           fall;
    logic           dataBit;

    rx_state_e      state_q, state_d;
    logic [2:0]     bitCnt_q, bitCnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] toCnt_q, toCnt_d;
    logic           byteValid_q, byteValid_d;
    logic           frameErr_q, frameErr_d;
    logic           timeout_q, timeout_d;

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filtCnt_d   = filtCnt_q;
        filtLevel_d = filtLevel_q;
        if (clkSync_q[1] == filtLevel_q) begin
            filtCnt_d = '0;
        end else if (filtCnt_q == FILT_LAST) begin
            filtLevel_d = ~filtLevel_q;
            filtCnt_d   = '0;
        end else begin
            filtCnt_d = filtCnt_q + 1'b1;
        end
    end

    assign fall    = filtLevel_q & ~filtLevel_d;
    assign dataBit = dataSync_q[1];

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        timeout_d   = 1'b0;
        toCnt_d     = (state_q == RX_IDLE || fall) ? '0 : toCnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dataBit) begin
                        state_d  = RX_DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d  = {dataBit, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_d = dataBit;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (dataBit && (^{shift_q, parity_q})) byteValid_d = 1'b1;
                    else                                   frameErr_d  = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && toCnt_q == TO_LAST) begin
            state_d   = RX_IDLE;
            timeout_d = 1'b1;
            toCnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_q   <= 2'b11;
            dataSync_q  <= 2'b11;
            filtCnt_q   <= '0;
            filtLevel_q <= 1'b1;
            state_q     <= RX_IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            toCnt_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            clkSync_q   <= {clkSync_q[0], ps2_clk};
            dataSync_q  <= {dataSync_q[0], ps2_data};
            filtCnt_q   <= filtCnt_d;
            filtLevel_q <= filtLevel_d;
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            toCnt_q     <= toCnt_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = byteValid_q;
    assign frame_err  = frameErr_q;
    assign rx_timeout = timeout_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder for the Tetris controller: turns make/break scan codes
// of the game keys into a held 2-bit command plus a new-press strobe.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] keyboard_signal,
    output logic       cmd_pulse,
    output logic       frame_err
);

    logic [7:0] byteData;
    logic       byteValid;
    logic       rxErr;
    logic       rxTimeout;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (byteData),
        .byte_valid (byteValid),
        .frame_err  (rxErr),
        .rx_timeout (rxTimeout)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [8:0] heldKey_q, heldKey_d;
    logic       heldValid_q, heldValid_d;
    logic [1:0] cmd_q, cmd_d;
    logic       pulse_q, pulse_d;
    logic [2:0] keyInfo;
    logic       isHeld;

    assign keyInfo = keyDecode(ext_q, byteData);
    assign isHeld  = heldValid_q && (heldKey_q == {ext_q, byteData});

    // Held key is tracked by full scan code so two physical keys sharing a
    // command still count as different presses.
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        heldKey_d   = heldKey_q;
        heldValid_d = heldValid_q;
        cmd_d       = cmd_q;
        pulse_d     = 1'b0;
        if (rxErr || rxTimeout) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byteValid) begin
            if (byteData == SC_EXT) begin
                ext_d = 1'b1;
            end else if (byteData == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (keyInfo[2]) begin
                    if (!brk_q) begin
                        if (!isHeld) begin
                            heldKey_d   = {ext_q, byteData};
                            heldValid_d = 1'b1;
                            cmd_d       = keyInfo[1:0];
                            pulse_d     = 1'b1;
                        end
                    end else if (isHeld) begin
                        heldValid_d = 1'b0;
                        cmd_d       = CMD_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            heldKey_q   <= 9'h000;
            heldValid_q <= 1'b0;
            cmd_q       <= CMD_IDLE;
            pulse_q     <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            heldKey_q   <= heldKey_d;
            heldValid_q <= heldValid_d;
            cmd_q       <= cmd_d;
            pulse_q     <= pulse_d;
        end
    end

    assign keyboard_signal = cmd_q;
    assign cmd_pulse       = pulse_q;
    assign frame_err       = rxErr;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames and checks the held
// command, strobes, latency, error, timeout, glitch and reset behaviour.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int HALF = 30;
    localparam int TO   = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] keyboard_signal;
    logic       cmd_pulse;
    logic       frame_err;

    int checkCount = 0;
    int failCount  = 0;
    int pulseCount = 0;
    int errCount   = 0;
    int lastLat    = -1;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keyboard_signal (keyboard_signal),
        .cmd_pulse       (cmd_pulse),
        .frame_err       (frame_err)
    );

    always @(negedge clk) begin
        if (cmd_pulse === 1'b1) pulseCount++;
        if (frame_err === 1'b1) errCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Sends the first nBits of an 11-bit frame; the stop-bit low phase also
    // records how many posedges pass before cmd_pulse shows up.
    task automatic applyStimulus(input logic [7:0] code, input bit badPar, input int nBits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ badPar, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                lastLat = -1;
                for (int c = 1; c <= HALF; c++) begin
                    @(posedge clk);
                    #1;
                    if (cmd_pulse === 1'b1 && lastLat < 0) lastLat = c;
                end
                @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 11);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_kbd", 32'(keyboard_signal), 32'(CMD_IDLE));
        checkOutput("reset_pulse", 32'(cmd_pulse), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        checkOutput("reset_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Extended left make and break, with stop-fall to pulse latency
        sendByte(8'hE0);
        checkOutput("ext_prefix_no_change", 32'(keyboard_signal), 32'(CMD_IDLE));
        sendByte(8'h6B);
        checkOutput("left_make", 32'(keyboard_signal), 32'(CMD_LEFT));
        checkOutput("left_latency", 32'(lastLat), 32'd11);
        checkOutput("left_pulse_count", 32'(pulseCount), 32'd1);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
        checkOutput("left_break", 32'(keyboard_signal), 32'(CMD_IDLE));
        checkOutput("break_no_pulse", 32'(pulseCount), 32'd1);

        // Rotate with typematic repeats
        sendByte(8'h1D);
        checkOutput("rotate_make", 32'(keyboard_signal), 32'(CMD_ROTATE));
        sendByte(8'h1D);
        sendByte(8'h1D);
        checkOutput("rotate_repeat", 32'(keyboard_signal), 32'(CMD_ROTATE));
        checkOutput("rotate_one_pulse", 32'(pulseCount), 32'd2);
        sendByte(8'hF0); sendByte(8'h1D);
        checkOutput("rotate_break", 32'(keyboard_signal), 32'(CMD_IDLE));

        // Last key pressed wins; releasing the older key does nothing
        sendByte(8'h1C);
        checkOutput("a_make", 32'(keyboard_signal), 32'(CMD_LEFT));
        sendByte(8'h23);
        checkOutput("d_over_a", 32'(keyboard_signal), 32'(CMD_RIGHT));
        checkOutput("d_pulse", 32'(pulseCount), 32'd4);
        sendByte(8'hF0); sendByte(8'h1C);
        checkOutput("a_break_ignored", 32'(keyboard_signal), 32'(CMD_RIGHT));
        sendByte(8'hF0); sendByte(8'h23);
        checkOutput("d_break", 32'(keyboard_signal), 32'(CMD_IDLE));

        // Parity error
        applyStimulus(8'h6B, 1'b1, 11);
        checkOutput("parity_err_count", 32'(errCount), 32'd1);
        checkOutput("parity_err_kbd", 32'(keyboard_signal), 32'(CMD_IDLE));
        sendByte(8'hE0); sendByte(8'h74);
        checkOutput("right_after_err", 32'(keyboard_signal), 32'(CMD_RIGHT));
        checkOutput("right_pulse", 32'(pulseCount), 32'd5);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
        checkOutput("right_break", 32'(keyboard_signal), 32'(CMD_IDLE));

        // Partial frame abandoned by timeout clears the E0 prefix
        sendByte(8'hE0);
        applyStimulus(8'h6B, 1'b0, 4);
        repeat (TO + 200) @(negedge clk);
        checkOutput("timeout_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        checkOutput("timeout_ext", 32'(dut.ext_q), 32'd0);
        checkOutput("timeout_no_err", 32'(errCount), 32'd1);
        sendByte(8'h74);
        checkOutput("plain_74_ignored", 32'(keyboard_signal), 32'(CMD_IDLE));
        checkOutput("plain_74_no_pulse", 32'(pulseCount), 32'd5);

        // Short ps2_clk glitches while data is low must not start a frame
        ps2_data = 1'b0;
        for (int g = 0; g < 10; g++) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checkOutput("glitch_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        ps2_data = 1'b1;
        sendByte(8'h1C);
        checkOutput("after_glitch_make", 32'(keyboard_signal), 32'(CMD_LEFT));
        sendByte(8'hE0); sendByte(8'h74);
        checkOutput("held_right", 32'(keyboard_signal), 32'(CMD_RIGHT));
        checkOutput("held_right_pulse", 32'(pulseCount), 32'd7);

        // Reset in the middle of a frame
        applyStimulus(8'h1D, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_kbd", 32'(keyboard_signal), 32'(CMD_IDLE));
        checkOutput("midreset_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (TO + 200) @(negedge clk);
        sendByte(8'h23);
        checkOutput("post_reset_make", 32'(keyboard_signal), 32'(CMD_RIGHT));
        checkOutput("post_reset_pulse", 32'(pulseCount), 32'd8);
        checkOutput("final_err_count", 32'(errCount), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
